// File: rtl/multicycle_sequencer_pkg.sv
// Shared state encoding for the multi-cycle sequencer.
// Also says which states wait on an ack.
package multicycle_sequencer_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    SEQ_IDLE   = 4'd0,
    SEQ_FETCH  = 4'd1,
    SEQ_DECODE = 4'd2,
    SEQ_EXEC   = 4'd3,
    SEQ_MEM    = 4'd4,
    SEQ_WB     = 4'd5,
    SEQ_PC     = 4'd6,
    SEQ_HALT   = 4'd7,
    SEQ_FAULT  = 4'd8
  } seq_state_t;

  function automatic logic waits_ack(seq_state_t s);
    return (s == SEQ_FETCH) || (s == SEQ_DECODE) ||
           (s == SEQ_MEM)   || (s == SEQ_WB);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Request/ack bundle between the sequencer and IMEM/DECODER/DMEM/REG/PC.
// The sequencer is the master.
interface multicycle_sequencer_if;
  logic instrfetch;
  logic instr_fetched;
  logic decode;
  logic id_comp;
  logic halt;
  logic memread;
  logic memwrite;
  logic regwrite;
  logic mem_req;
  logic mem_we;
  logic mem_ack;
  logic wb;
  logic wb_comp;
  logic PCwrite;

  modport master (
    output instrfetch, decode, mem_req,
    output mem_we, wb, PCwrite,
    input  instr_fetched, id_comp, halt,
    input  memread, memwrite, regwrite,
    input  mem_ack, wb_comp
  );

  modport slave (
    input  instrfetch, decode, mem_req,
    input  mem_we, wb, PCwrite,
    output instr_fetched, id_comp, halt,
    output memread, memwrite, regwrite,
    output mem_ack, wb_comp
  );
endinterface

// File: rtl/multicycle_sequencer_watchdog.sv
// Wait-cycle watchdog: expired is high on the TIMEOUT-th
// consecutive waiting cycle of a state.
module seq_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  assign expired = en && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32I core with
// req/ack stages, watchdog, single-step and retire counter.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32,
  parameter int STEP_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step_mode,
  input  logic                  step_pulse,
  multicycle_sequencer_if.master bus,
  output logic [STATE_W-1:0]    state,
  output logic [CNT_W-1:0]      retired,
  output logic                  halted,
  output logic                  fault
);

  localparam bit STEP_ON = (STEP_EN != 0);

  seq_state_t cur;
  seq_state_t nxt;
  logic       expired;
  logic       pulse_q;
  logic       armed;
  logic       rise;

  // armed stays low until the button is seen released after reset
  assign rise  = step_pulse && !pulse_q && armed;
  assign state = cur;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (nxt != cur),
    .en      (waits_ack(cur)),
    .expired (expired)
  );

  always_comb begin
    nxt = cur;
    unique case (cur)
      SEQ_IDLE: begin
        if (!(step_mode && STEP_ON) || rise)
          nxt = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        if (bus.instr_fetched)
          nxt = SEQ_DECODE;
        else if (expired)
          nxt = SEQ_FAULT;
      end
      SEQ_DECODE: begin
        if (bus.id_comp) begin
          if (bus.halt)
            nxt = SEQ_HALT;
          else if (bus.memread && bus.memwrite)
            nxt = SEQ_FAULT;
          else
            nxt = SEQ_EXEC;
        end else if (expired) begin
          nxt = SEQ_FAULT;
        end
      end
      SEQ_EXEC: begin
        if (bus.memread || bus.memwrite)
          nxt = SEQ_MEM;
        else if (bus.regwrite)
          nxt = SEQ_WB;
        else
          nxt = SEQ_PC;
      end
      SEQ_MEM: begin
        if (bus.mem_ack)
          nxt = bus.regwrite ? SEQ_WB : SEQ_PC;
        else if (expired)
          nxt = SEQ_FAULT;
      end
      SEQ_WB: begin
        if (bus.wb_comp)
          nxt = SEQ_PC;
        else if (expired)
          nxt = SEQ_FAULT;
      end
      SEQ_PC:    nxt = SEQ_IDLE;
      SEQ_HALT:  nxt = SEQ_HALT;
      SEQ_FAULT: nxt = SEQ_FAULT;
      default:   nxt = SEQ_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= SEQ_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      pulse_q <= step_pulse;
      if (!step_pulse)
        armed <= 1'b1;
    end
  end

  // outputs decoded from the next state so they line up with state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.instrfetch <= 1'b0;
      bus.decode     <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.wb         <= 1'b0;
      bus.PCwrite    <= 1'b0;
      halted         <= 1'b0;
      fault          <= 1'b0;
      retired        <= '0;
    end else begin
      bus.instrfetch <= (nxt == SEQ_FETCH);
      bus.decode     <= (nxt == SEQ_DECODE);
      bus.mem_req    <= (nxt == SEQ_MEM);
      bus.mem_we     <= (nxt == SEQ_MEM) && bus.memwrite;
      bus.wb         <= (nxt == SEQ_WB);
      bus.PCwrite    <= (nxt == SEQ_PC);
      halted         <= (nxt == SEQ_HALT);
      fault          <= (nxt == SEQ_FAULT);
      if (cur == SEQ_PC)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction cycle traces
// built from instruction kind and random ack delays.
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam int S_IDLE  = 0;
  localparam int S_FETCH = 1;
  localparam int S_DEC   = 2;
  localparam int S_EXEC  = 3;
  localparam int S_MEM   = 4;
  localparam int S_WB    = 5;
  localparam int S_PC    = 6;
  localparam int S_HALT  = 7;
  localparam int S_FAULT = 8;

  localparam int K_BR  = 0;
  localparam int K_R   = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_HLT = 4;
  localparam int K_ILL = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_mode = 1'b0;
  logic          step_pulse = 1'b0;
  logic [3:0]    state;
  logic [CW-1:0] retired;
  logic          halted;
  logic          fault;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(
    .TIMEOUT (TO),
    .CNT_W   (CW),
    .STEP_EN (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_mode  (step_mode),
    .step_pulse (step_pulse),
    .bus        (bus),
    .state      (state),
    .retired    (retired),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int exp_ret = 0;
  bit cur_mr, cur_mw, cur_rw, cur_halt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  task automatic set_kind(input int kind);
    cur_mr   = (kind == K_LD) || (kind == K_ILL);
    cur_mw   = (kind == K_ST) || (kind == K_ILL);
    cur_rw   = (kind == K_R)  || (kind == K_LD);
    cur_halt = (kind == K_HLT);
  endtask

  // check one cycle of expected state, drive that cycle's inputs
  task automatic cyc(input int st, input bit ack);
    logic [7:0] obs, expv;
    obs  = {bus.instrfetch, bus.decode, bus.mem_req, bus.mem_we,
            bus.wb, bus.PCwrite, halted, fault};
    expv = {st == S_FETCH, st == S_DEC, st == S_MEM,
            (st == S_MEM) && cur_mw, st == S_WB, st == S_PC,
            st == S_HALT, st == S_FAULT};
    chk("state", 32'(state), 32'(st));
    chk("outputs", 32'(obs), 32'(expv));
    chk("retired", 32'(retired), 32'(exp_ret % (1 << CW)));
    bus.instr_fetched = (st == S_FETCH) ? ack : 1'($urandom);
    bus.id_comp       = (st == S_DEC)   ? ack : 1'($urandom);
    bus.mem_ack       = (st == S_MEM)   ? ack : 1'($urandom);
    bus.wb_comp       = (st == S_WB)    ? ack : 1'($urandom);
    bus.halt          = (st == S_DEC) ? cur_halt : 1'($urandom);
    if (st >= S_DEC && st <= S_WB) begin
      bus.memread  = cur_mr;
      bus.memwrite = cur_mw;
      bus.regwrite = cur_rw;
    end else begin
      bus.memread  = 1'($urandom);
      bus.memwrite = 1'($urandom);
      bus.regwrite = 1'($urandom);
    end
    @(negedge clk);
    if (st == S_PC) exp_ret++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.instr_fetched = 1'b0;
    bus.id_comp = 1'b0;
    bus.mem_ack = 1'b0;
    bus.wb_comp = 1'b0;
    @(negedge clk);
    exp_ret = 0;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_outputs", 32'({bus.instrfetch, bus.decode, bus.mem_req,
        bus.mem_we, bus.wb, bus.PCwrite, halted, fault}), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
  endtask

  // d waiting cycles then ack; too long a wait ends in FAULT
  task automatic stage(input int st, input int d, output bit ok);
    ok = 1'b1;
    for (int k = 0; k <= d; k++) begin
      if (k == TO) begin
        ok = 1'b0;
        break;
      end
      cyc(st, k == d);
    end
  endtask

  task automatic dead(input int st);
    repeat (3) cyc(st, 1'b0);
    do_reset();
  endtask

  task automatic instr(input int kind, input int df, input int dd,
                       input int dm, input int dw);
    bit ok;
    set_kind(kind);
    cyc(S_IDLE, 1'b0);
    stage(S_FETCH, df, ok);
    if (!ok) begin dead(S_FAULT); return; end
    stage(S_DEC, dd, ok);
    if (!ok) begin dead(S_FAULT); return; end
    if (cur_halt) begin dead(S_HALT); return; end
    if (cur_mr && cur_mw) begin dead(S_FAULT); return; end
    cyc(S_EXEC, 1'b0);
    if (cur_mr || cur_mw) begin
      stage(S_MEM, dm, ok);
      if (!ok) begin dead(S_FAULT); return; end
    end
    if (cur_rw) begin
      stage(S_WB, dw, ok);
      if (!ok) begin dead(S_FAULT); return; end
    end
    cyc(S_PC, 1'b0);
  endtask

  function automatic int rd();
    return ($urandom_range(0, 24) == 0) ? TO : int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    bit ok;
    int r;
    int kind;
    bus.instr_fetched = 1'b0;
    bus.id_comp = 1'b0;
    bus.mem_ack = 1'b0;
    bus.wb_comp = 1'b0;
    bus.halt = 1'b0;
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    bus.regwrite = 1'b0;
    do_reset();

    // minimum-latency instructions of each kind
    instr(K_R, 0, 0, 0, 0);
    instr(K_LD, 0, 0, 0, 0);
    instr(K_ST, 0, 0, 0, 0);
    instr(K_BR, 0, 0, 0, 0);
    // ack on the limit cycle wins; one more cycle faults
    instr(K_LD, TO - 1, TO - 1, TO - 1, TO - 1);
    instr(K_BR, TO, 0, 0, 0);
    instr(K_ST, 0, 0, TO, 0);
    instr(K_R, 0, 0, 0, TO);
    instr(K_HLT, 0, 1, 0, 0);
    instr(K_ILL, 1, 0, 0, 0);

    // counter wrap: 17 retirements from reset
    for (int i = 0; i < 17; i++)
      instr(int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)),
            int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
            int'($urandom_range(0, TO - 1)));
    chk("wrap", 32'(retired), 32'd1);

    // reset during MEM with a long mem_ack delay
    set_kind(K_LD);
    cyc(S_IDLE, 1'b0);
    stage(S_FETCH, 0, ok);
    stage(S_DEC, 0, ok);
    cyc(S_EXEC, 1'b0);
    cyc(S_MEM, 1'b0);
    cyc(S_MEM, 1'b0);
    do_reset();
    chk("mem_req_after_rst", 32'(bus.mem_req), 32'd0);

    // single-step: held button steps once, next press steps again
    step_mode = 1'b1;
    set_kind(K_BR);
    repeat (5) cyc(S_IDLE, 1'b0);
    step_pulse = 1'b1;
    instr(K_BR, 0, 0, 0, 0);
    repeat (20) cyc(S_IDLE, 1'b0);
    chk("step_one", 32'(retired), 32'd1);
    step_pulse = 1'b0;
    cyc(S_IDLE, 1'b0);
    step_pulse = 1'b1;
    instr(K_R, 1, 0, 0, 2);
    repeat (3) cyc(S_IDLE, 1'b0);
    chk("step_two", 32'(retired), 32'd2);
    step_pulse = 1'b0;
    step_mode = 1'b0;
    do_reset();

    // random instruction stream
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 29));
      kind = (r == 0) ? K_HLT : (r == 1) ? K_ILL : (r % 4);
      instr(kind, rd(), rd(), rd(), rd());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
